// File: rtl/spi_slave_pkg.sv
// Shared SPI slave constants: standard word targets, SDI lane counts and the RX shift helper.
// Targets are last-cycle indices, so a word spans target+1 sclk cycles.
package spi_slave_pkg;

    localparam logic [7:0] CMD_TRGT_SGL   = 8'h07;
    localparam logic [7:0] CMD_TRGT_QUAD  = 8'h01;
    localparam logic [7:0] WORD_TRGT_SGL  = 8'h1F;
    localparam logic [7:0] WORD_TRGT_QUAD = 8'h07;
    localparam logic [7:0] WORD_TRGT_DUAL = 8'h0F;

    localparam int unsigned SDI_LANES_SGL  = 1;
    localparam int unsigned SDI_LANES_DUAL = 2;
    localparam int unsigned SDI_LANES_QUAD = 4;
    localparam int unsigned RX_WORD_W      = 32;

    typedef enum logic [1:0] {
        RX_MODE_SGL  = 2'd0,
        RX_MODE_DUAL = 2'd1,
        RX_MODE_QUAD = 2'd2
    } rx_mode_e;

    // Lane 3 (or the highest active lane) lands in the more significant bit of each group.
    function automatic logic [RX_WORD_W-1:0] rx_shift(
        input logic [RX_WORD_W-1:0] cur,
        input logic [3:0]           sdi,
        input rx_mode_e             mode
    );
        case (mode)
            RX_MODE_QUAD: rx_shift = {cur[RX_WORD_W-5:0], sdi};
            RX_MODE_DUAL: rx_shift = {cur[RX_WORD_W-3:0], sdi[1:0]};
            default:      rx_shift = {cur[RX_WORD_W-2:0], sdi[0]};
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_rx_shifter.sv
// SPI slave RX serial-to-parallel stage: shifts SDI lanes every sclk edge, pulses data_ready per word.
// Define SPI_RX_DUAL_EN to add the en_dual port and 2-lane shifting.
module spi_slave_rx_shifter
    import spi_slave_pkg::*;
#(
    parameter int unsigned      CNT_W    = 8,
    parameter logic [CNT_W-1:0] RST_TRGT = CNT_W'(CMD_TRGT_SGL)
) (
    input  logic                 sclk,
    input  logic                 sys_rst,
    input  logic                 sdi0,
    input  logic                 sdi1,
    input  logic                 sdi2,
    input  logic                 sdi3,
    input  logic                 en_quad,
`ifdef SPI_RX_DUAL_EN
    input  logic                 en_dual,
`endif
    input  logic [CNT_W-1:0]     counter_in,
    input  logic                 counter_in_upd,
    output logic [RX_WORD_W-1:0] data,
    output logic                 data_ready
);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     trgt_q, trgt_d;
    logic                 rdy_q, rdy_d;
    logic [RX_WORD_W-1:0] data_q, data_d;
    logic                 word_done;
    rx_mode_e             mode;

    always_comb begin
        mode = RX_MODE_SGL;
        if (en_quad) begin
            mode = RX_MODE_QUAD;
        end
`ifdef SPI_RX_DUAL_EN
        else if (en_dual) begin
            mode = RX_MODE_DUAL;
        end
`endif
    end

    // >= rather than == so a target lowered below the running count closes the word at once.
    always_comb begin
        word_done = (cnt_q >= trgt_q);
        cnt_d     = word_done ? '0 : cnt_q + CNT_W'(1);
        rdy_d     = word_done;
        trgt_d    = counter_in_upd ? counter_in : trgt_q;
        data_d    = rx_shift(data_q, {sdi3, sdi2, sdi1, sdi0}, mode);
    end

    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            trgt_q <= RST_TRGT;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trgt_q <= trgt_d;
            rdy_q  <= rdy_d;
        end
    end

    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data       = data_q;
    assign data_ready = rdy_q;

endmodule

// File: tb/tb_spi_slave_rx_shifter.sv
// Bench for spi_slave_rx_shifter: directed word scenarios plus random traffic against a bit-history model.
// Build with SPI_RX_DUAL_EN defined to also exercise the 2-lane mode.
module tb_spi_slave_rx_shifter;
    import spi_slave_pkg::*;

    logic        sclk = 1'b0;
    logic        sys_rst;
    logic        sdi0, sdi1, sdi2, sdi3;
    logic        en_quad;
    logic [7:0]  counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_ready;
`ifdef SPI_RX_DUAL_EN
    logic        en_dual;
`endif

    always #5 sclk = ~sclk;

    spi_slave_rx_shifter u_dut (
        .sclk           (sclk),
        .sys_rst        (sys_rst),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad        (en_quad),
`ifdef SPI_RX_DUAL_EN
        .en_dual        (en_dual),
`endif
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_ready     (data_ready)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int pulses   = 0;

    // Model: every bit ever sampled since reset (oldest first) plus cycles elapsed in the current word.
    bit hist[$];
    int m_pos  = 0;
    int m_trgt = int'(CMD_TRGT_SGL);
    bit m_rdy  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < hist.size(); i++) v[hist.size() - 1 - i] = hist[i];
        return v;
    endfunction

    task automatic model_edge();
        int         lanes;
        logic [3:0] pads;
        if (sys_rst) begin
            hist.delete();
            m_pos  = 0;
            m_trgt = int'(CMD_TRGT_SGL);
            m_rdy  = 1'b0;
            return;
        end
        pads  = {sdi3, sdi2, sdi1, sdi0};
        lanes = en_quad ? 4 : 1;
`ifdef SPI_RX_DUAL_EN
        if (!en_quad && en_dual) lanes = 2;
`endif
        for (int l = lanes - 1; l >= 0; l--) hist.push_back(pads[l]);
        while (hist.size() > 32) void'(hist.pop_front());
        // A word has run its course once trgt+1 cycles have been spent in it.
        m_rdy = (m_pos >= m_trgt);
        m_pos = m_rdy ? 0 : m_pos + 1;
        if (counter_in_upd) m_trgt = int'(counter_in);
    endtask

    task automatic step(input string tag);
        @(posedge sclk);
        model_edge();
        #1;
        check_eq({tag, "_data"}, data, model_data());
        check_eq({tag, "_rdy"}, {31'b0, data_ready}, {31'b0, m_rdy});
        if (data_ready) pulses++;
    endtask

    // Sends the low ncyc*lanes bits of w, most significant group first; target update lasts one edge.
    task automatic send_word(input logic [31:0] w, input int ncyc, input int lanes, input string tag);
        logic [31:0] chunk;
        for (int c = 0; c < ncyc; c++) begin
            chunk = (w >> ((ncyc - 1 - c) * lanes)) & ((32'd1 << lanes) - 32'd1);
            {sdi3, sdi2, sdi1, sdi0} = chunk[3:0];
            step(tag);
            counter_in_upd = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] w;
        int          first;

        sys_rst = 1'b1;
        {sdi3, sdi2, sdi1, sdi0} = 4'h0;
        en_quad = 1'b0;
`ifdef SPI_RX_DUAL_EN
        en_dual = 1'b0;
`endif
        counter_in = 8'h00;
        counter_in_upd = 1'b0;

        step("rst");
        {sdi3, sdi2, sdi1, sdi0} = 4'hF;
        counter_in = 8'h03;
        counter_in_upd = 1'b1;
        step("rst_override");
        check_eq("rst_data", data, 32'h0);
        check_eq("rst_rdy", {31'b0, data_ready}, 32'h0);
        counter_in_upd = 1'b0;
        sys_rst = 1'b0;

        // Command byte in single mode after reset.
        pulses = 0;
        send_word(32'h0B, 8, 1, "cmd");
        check_eq("cmd_rdy", {31'b0, data_ready}, 32'h1);
        check_eq("cmd_byte", {24'b0, data[7:0]}, 32'h0B);
        check_eq("cmd_pulses", pulses, 1);

        // Quad word, target changed in the data_ready cycle.
        en_quad = 1'b1;
        counter_in = WORD_TRGT_QUAD;
        counter_in_upd = 1'b1;
        send_word(32'h12345678, 8, 4, "quad");
        check_eq("quad_word", data, 32'h12345678);
        check_eq("quad_rdy", {31'b0, data_ready}, 32'h1);
        pulses = 0;
        w = $urandom;
        send_word(w, 8, 4, "quad2");
        check_eq("quad2_word", data, w);
        check_eq("quad2_pulses", pulses, 1);

        // Back-to-back single-mode 32-bit words.
        en_quad = 1'b0;
        counter_in = WORD_TRGT_SGL;
        counter_in_upd = 1'b1;
        pulses = 0;
        send_word(32'hDEADBEEF, 32, 1, "sgl1");
        check_eq("sgl1_word", data, 32'hDEADBEEF);
        check_eq("sgl1_pulses", pulses, 1);
        pulses = 0;
        send_word(32'hCAFEF00D, 32, 1, "sgl2");
        check_eq("sgl2_word", data, 32'hCAFEF00D);
        check_eq("sgl2_rdy", {31'b0, data_ready}, 32'h1);
        check_eq("sgl2_pulses", pulses, 1);

        // Target lowered mid-word once ten cycles have elapsed.
        send_word($urandom, 10, 1, "mid_pre");
        counter_in = 8'h05;
        counter_in_upd = 1'b1;
        step("mid_upd");
        counter_in_upd = 1'b0;
        check_eq("mid_upd_rdy", {31'b0, data_ready}, 32'h0);
        step("mid_done");
        check_eq("mid_done_rdy", {31'b0, data_ready}, 32'h1);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            {sdi3, sdi2, sdi1, sdi0} = 4'($urandom);
            step("mid_next");
            if (data_ready && first == 0) first = i;
        end
        check_eq("mid_next_len", first, 6);

        // Reset in the middle of a word, then a fresh command byte.
        counter_in = WORD_TRGT_SGL;
        counter_in_upd = 1'b1;
        send_word($urandom, 14, 1, "rst_pre");
        sys_rst = 1'b1;
        step("rst_mid");
        check_eq("rst_mid_data", data, 32'h0);
        check_eq("rst_mid_rdy", {31'b0, data_ready}, 32'h0);
        sys_rst = 1'b0;
        w = 32'($urandom_range(0, 255));
        pulses = 0;
        send_word(w, 8, 1, "cmd2");
        check_eq("cmd2_byte", {24'b0, data[7:0]}, w);
        check_eq("cmd2_pulses", pulses, 1);

`ifdef SPI_RX_DUAL_EN
        en_dual = 1'b1;
        counter_in = WORD_TRGT_DUAL;
        counter_in_upd = 1'b1;
        pulses = 0;
        send_word(32'hA5A50FF0, 16, 2, "dual");
        check_eq("dual_word", data, 32'hA5A50FF0);
        check_eq("dual_pulses", pulses, 1);
        en_quad = 1'b1;
        counter_in = WORD_TRGT_QUAD;
        counter_in_upd = 1'b1;
        w = $urandom;
        send_word(w, 8, 4, "dual_quad");
        check_eq("dual_quad_word", data, w);
        en_quad = 1'b0;
        en_dual = 1'b0;
`endif

        // Random traffic: lanes, mode switches, target updates and resets at arbitrary points.
        for (int i = 0; i < 3000; i++) begin
            {sdi3, sdi2, sdi1, sdi0} = 4'($urandom);
            counter_in_upd = ($urandom_range(0, 7) == 0);
            counter_in = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) en_quad = ~en_quad;
`ifdef SPI_RX_DUAL_EN
            if ($urandom_range(0, 15) == 0) en_dual = ~en_dual;
`endif
            sys_rst = ($urandom_range(0, 199) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
